// File: rtl/timer_pkg.sv
// Shared constants for the multi-channel countdown timer.
package timer_pkg;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_CHANNELS   = 4;
  localparam int DEF_PRESCALE_W = 8;
endpackage

// File: rtl/timer_channel.sv
// One countdown channel: counter, reload and mode state, busy flag and expire pulse.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] cycles,
  input  logic             periodic,
  input  logic             stop,
  output logic             busy,
  output logic             expire
);

  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] reload;
  logic             mode;

  // Priority: reset > stop > load > tick; expire drops on every path except expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      reload  <= '0;
      mode    <= MODE_ONESHOT;
      expire  <= 1'b0;
    end else if (stop) begin
      counter <= '0;
      mode    <= MODE_ONESHOT;
      expire  <= 1'b0;
    end else if (load) begin
      counter <= cycles;
      reload  <= cycles;
      mode    <= periodic;
      expire  <= 1'b0;
    end else if (tick && counter == WIDTH'(1)) begin
      counter <= (mode == MODE_PERIODIC) ? reload : '0;
      expire  <= 1'b1;
    end else begin
      if (tick && counter != '0) counter <= counter - WIDTH'(1);
      expire <= 1'b0;
    end
  end

  assign busy = (counter != '0);

  a_load: assert property (@(posedge clk) disable iff (reset)
    (load && !stop) |=> counter == $past(cycles));
  a_dec: assert property (@(posedge clk) disable iff (reset)
    (tick && !load && !stop && counter > WIDTH'(1)) |=> counter == $past(counter) - WIDTH'(1));
  a_busy: assert property (@(posedge clk) busy == (counter != '0));
  a_exp_src: assert property (@(posedge clk) disable iff (reset)
    expire |-> $past(counter) == WIDTH'(1));
  a_no_exp: assert property (@(posedge clk) (reset || stop) |=> !expire);

  c_reload:  cover property (@(posedge clk) expire && mode == MODE_PERIODIC);
  c_oneshot: cover property (@(posedge clk) expire && !busy);

endmodule

// File: rtl/multi_timer.sv
// Multi-channel countdown timer sharing one free-running prescaler.
module multi_timer
  import timer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PRESCALE_W-1:0]     prescale_div,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] cycles,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS-1:0]       stop,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       expire,
  output logic                      any_expire
);

  logic [PRESCALE_W-1:0] pcnt;
  logic                  tick;

  // >= rather than == so lowering the divider below pcnt ticks at once instead of wrapping.
  assign tick = (pcnt >= prescale_div);

  always_ff @(posedge clk) begin
    if (reset)     pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + PRESCALE_W'(1);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .load     (load[i]),
      .cycles   (cycles[i*WIDTH +: WIDTH]),
      .periodic (periodic[i]),
      .stop     (stop[i]),
      .busy     (busy[i]),
      .expire   (expire[i])
    );
  end

  assign any_expire = |expire;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: one-shot, prescaled, periodic/stop, load override, reset.
module tb_multi_timer;
  localparam int W  = 16;
  localparam int CH = 4;
  localparam int PW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [PW-1:0]   prescale_div = '0;
  logic [CH-1:0]   load = '0;
  logic [CH-1:0]   periodic = '0;
  logic [CH-1:0]   stop = '0;
  logic [CH*W-1:0] cycles = '0;
  logic [CH-1:0]   busy;
  logic [CH-1:0]   expire;
  logic            any_expire;

  int n_chk  = 0;
  int n_pass = 0;

  multi_timer #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .prescale_div (prescale_div),
    .load         (load),
    .cycles       (cycles),
    .periodic     (periodic),
    .stop         (stop),
    .busy         (busy),
    .expire       (expire),
    .any_expire   (any_expire)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clock n edges, clearing strobes after the first; tally channel ch and the other channels.
  task automatic observe(input int ch, input int n,
                         output int nb, output int ne, output int fe, output int na,
                         output logic oth);
    logic [CH-1:0] mask;
    mask = ~(CH'(1) << ch);
    nb = 0; ne = 0; fe = -1; na = 0; oth = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0) begin
        load = '0;
        stop = '0;
      end
      if (busy[ch]) nb++;
      if (expire[ch]) begin
        ne++;
        if (fe < 0) fe = i;
      end
      if (any_expire) na++;
      if (|((busy | expire) & mask)) oth = 1'b1;
    end
  endtask

  int   nb, ne, fe, na;
  logic oth;

  initial begin
    // Reset state
    step(); step();
    reset = 1'b0;
    step();
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_expire", 32'(expire), 32'h0);
    check("rst_any", 32'(any_expire), 32'h0);

    // 1. div=0, ch0 one-shot C=5
    cycles[0*W +: W] = 16'd5; load[0] = 1'b1;
    observe(0, 10, nb, ne, fe, na, oth);
    check("t1_busy_cycles", nb, 5);
    check("t1_expire_cnt", ne, 1);
    check("t1_expire_at", fe, 5);
    check("t1_any_cnt", na, 1);

    // 2. div=2 from a known prescaler phase, ch1 one-shot C=3
    reset = 1'b1; prescale_div = 8'd2;
    step(); step();
    reset = 1'b0;
    cycles[1*W +: W] = 16'd3; load[1] = 1'b1;
    observe(1, 12, nb, ne, fe, na, oth);
    check("t2_busy_cycles", nb, 8);
    check("t2_expire_cnt", ne, 1);
    check("t2_expire_at", fe, 8);
    check("t2_others_quiet", 32'(oth), 32'h0);

    // 3. div=0, ch2 periodic C=4, then stop
    prescale_div = 8'd0;
    cycles[2*W +: W] = 16'd4; periodic[2] = 1'b1; load[2] = 1'b1;
    observe(2, 13, nb, ne, fe, na, oth);
    periodic = '0;
    check("t3_busy_cycles", nb, 13);
    check("t3_expire_cnt", ne, 3);
    check("t3_first_expire", fe, 4);
    stop[2] = 1'b1;
    observe(2, 10, nb, ne, fe, na, oth);
    check("t3_stop_busy", nb, 0);
    check("t3_stop_expire", ne, 0);

    // 4. ch3: reload on the expiring tick suppresses expire; load of 0 stays idle
    cycles[3*W +: W] = 16'd3; load[3] = 1'b1;
    observe(3, 3, nb, ne, fe, na, oth);
    check("t4_pre_busy", nb, 3);
    cycles[3*W +: W] = 16'd7; load[3] = 1'b1;
    step();
    load = '0;
    check("t4_ovr_expire", 32'(expire[3]), 32'h0);
    check("t4_ovr_busy", 32'(busy[3]), 32'h1);
    observe(3, 8, nb, ne, fe, na, oth);
    check("t4_restart_busy", nb, 6);
    check("t4_restart_expire_at", fe, 6);
    cycles[3*W +: W] = 16'd5; load[3] = 1'b1;
    step();
    cycles[3*W +: W] = 16'd0; load[3] = 1'b1;
    observe(3, 8, nb, ne, fe, na, oth);
    check("t4_zero_busy", nb, 0);
    check("t4_zero_expire", ne, 0);

    // 5. all channels C=2 in the same cycle
    for (int c = 0; c < CH; c++) cycles[c*W +: W] = 16'd2;
    load = '1;
    step();
    load = '0;
    check("t5_busy0", 32'(busy), 32'hf);
    step();
    check("t5_busy1", 32'(busy), 32'hf);
    check("t5_any_early", 32'(any_expire), 32'h0);
    step();
    check("t5_expire", 32'(expire), 32'hf);
    check("t5_any", 32'(any_expire), 32'h1);
    check("t5_idle", 32'(busy), 32'h0);
    step();
    check("t5_any_after", 32'(any_expire), 32'h0);

    // 6. reset while ch0 holds 1; prescaler must restart from 0
    prescale_div = 8'd7;
    step(); step(); step();
    cycles[0*W +: W] = 16'd1; load[0] = 1'b1;
    step();
    load = '0;
    check("t6_pre_busy", 32'(busy[0]), 32'h1);
    reset = 1'b1; prescale_div = 8'd3;
    step();
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_expire", 32'(expire), 32'h0);
    step();
    check("t6_rst_expire2", 32'(expire), 32'h0);
    reset = 1'b0;
    cycles[0*W +: W] = 16'd1; load[0] = 1'b1;
    observe(0, 6, nb, ne, fe, na, oth);
    check("t6_expire_at", fe, 3);
    check("t6_expire_cnt", ne, 1);
    check("t6_busy_cycles", nb, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
